ser2_tx: RTL and testbench

- Two-lane byte-to-serial transmitter; the transmit end of the two-lane serial link whose receive end is disp2.
- Each lane accepts bytes over a valid/ready interface and buffers them in a small FIFO.
- Each lane shifts bytes out MSB-first, one bit per clk, on a 1-bit line.
- Lanes send COM symbols (0xBC) to establish alignment and to fill idle time.

---
 rtl/ser2_pkg.sv | 15 +
 rtl/ser2_lane.sv | 132 +++++++++++++
 rtl/ser2_tx.sv | 77 +++++++
 tb/tb_ser2_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ser2_pkg.sv
// Shared constants and types for the two-lane serial transmitter.
//   ComSym       : alignment / idle symbol
//   SymW         : symbol width in bits
//   lane_state_e : per-lane state encoding
package ser2_pkg;

  localparam int unsigned SymW   = 8;
  localparam logic [7:0]  ComSym = 8'hBC;

  typedef enum logic {
    StInit   = 1'b0,
    StActive = 1'b1
  } lane_state_e;

endpackage

// File: rtl/ser2_lane.sv
// One transmit lane: byte FIFO, MSB-first shifter, bit/sync counters and state machine.
// Optional feature macro: SER2_TX_BYTECNT_EN adds the tx_cnt_o data-symbol counter.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   data_i/valid_i : write byte and request
//   ready_o        : FIFO not full (combinational from count)
//   out_o          : serial line, bit 7 of the shift register
//   data_act_o     : current symbol is a data byte
//   almost_full_o  : registered count >= DEPTH-1
//   tx_cnt_o       : saturating count of data-symbol loads (optional)
module ser2_lane
  import ser2_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  COM        = ComSym
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [SymW-1:0] data_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            out_o,
  output logic            data_act_o,
  output logic            almost_full_o
`ifdef SER2_TX_BYTECNT_EN
  ,
  output logic [15:0]     tx_cnt_o
`endif
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned SyncW = $clog2(SYNC_COUNT + 1);
  localparam logic [2:0]  BitLast = 3'd7;

  logic [SymW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [SymW-1:0] shift_q;
  logic [2:0]      bitcnt_q;
  logic [SyncW-1:0] sync_q;
  lane_state_e     state_q;
  logic            data_act_q;
  logic            almost_full_q;

  logic push, pop, load;

  assign ready_o = (count_q != CntW'(DEPTH));
  assign push    = valid_i && ready_o;
  assign load    = (bitcnt_q == BitLast);
  // Pop only on a load edge in ACTIVE, judged on the pre-edge count so a byte
  // pushed on that same edge waits for the next symbol.
  assign pop     = load && (state_q == StActive) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      shift_q       <= '0;
      bitcnt_q      <= BitLast;
      sync_q        <= '0;
      state_q       <= StInit;
      data_act_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q       <= count_d;
      almost_full_q <= (count_d >= CntW'(DEPTH - 1));
      if (load) begin
        bitcnt_q <= '0;
        unique case (state_q)
          StInit: begin
            shift_q    <= COM;
            data_act_q <= 1'b0;
            sync_q     <= sync_q + SyncW'(1);
            if (sync_q == SyncW'(SYNC_COUNT - 1)) state_q <= StActive;
          end
          StActive: begin
            if (count_q != '0) begin
              shift_q    <= mem_q[rd_ptr_q];
              data_act_q <= 1'b1;
            end else begin
              shift_q    <= COM;
              data_act_q <= 1'b0;
            end
          end
          default: state_q <= StInit;
        endcase
      end else begin
        shift_q  <= shift_q << 1;
        bitcnt_q <= bitcnt_q + 3'd1;
      end
    end
  end

  assign out_o         = shift_q[SymW-1];
  assign data_act_o    = data_act_q;
  assign almost_full_o = almost_full_q;

`ifdef SER2_TX_BYTECNT_EN
  logic [15:0] tx_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_cnt_q <= '0;
    end else if (pop && (tx_cnt_q != 16'hFFFF)) begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  assign tx_cnt_o = tx_cnt_q;
`endif

endmodule

// File: rtl/ser2_tx.sv
// Two-lane byte-to-serial transmitter (transmit end of the disp2 link).
// Optional feature macro: SER2_TX_BYTECNT_EN adds tx_cnt1/tx_cnt2 data-symbol counters.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   in_data*/in_valid*        : per-lane write byte and request
//   in_ready*                 : per-lane FIFO not full
//   out*                      : per-lane serial line, MSB first
//   data_act*                 : per-lane data-symbol indicator
//   almost_full_f*            : per-lane FIFO count >= DEPTH-1
//   tx_cnt1, tx_cnt2          : per-lane saturating data-symbol counts (optional)
module ser2_tx
  import ser2_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  COM        = ComSym
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data1,
  input  logic        in_valid1,
  output logic        in_ready1,
  input  logic [7:0]  in_data2,
  input  logic        in_valid2,
  output logic        in_ready2,
  output logic        out1,
  output logic        out2,
  output logic        data_act1,
  output logic        data_act2,
  output logic        almost_full_f1,
  output logic        almost_full_f2
`ifdef SER2_TX_BYTECNT_EN
  ,
  output logic [15:0] tx_cnt1,
  output logic [15:0] tx_cnt2
`endif
);

  ser2_lane #(
    .DEPTH      (DEPTH),
    .SYNC_COUNT (SYNC_COUNT),
    .COM        (COM)
  ) u_lane1 (
    .clk_i         (clk),
    .rst_ni        (reset),
    .data_i        (in_data1),
    .valid_i       (in_valid1),
    .ready_o       (in_ready1),
    .out_o         (out1),
    .data_act_o    (data_act1),
    .almost_full_o (almost_full_f1)
`ifdef SER2_TX_BYTECNT_EN
    ,
    .tx_cnt_o      (tx_cnt1)
`endif
  );

  ser2_lane #(
    .DEPTH      (DEPTH),
    .SYNC_COUNT (SYNC_COUNT),
    .COM        (COM)
  ) u_lane2 (
    .clk_i         (clk),
    .rst_ni        (reset),
    .data_i        (in_data2),
    .valid_i       (in_valid2),
    .ready_o       (in_ready2),
    .out_o         (out2),
    .data_act_o    (data_act2),
    .almost_full_o (almost_full_f2)
`ifdef SER2_TX_BYTECNT_EN
    ,
    .tx_cnt_o      (tx_cnt2)
`endif
  );

endmodule

// File: tb/tb_ser2_tx.sv
// Directed self-checking bench for ser2_tx (DEPTH=4, SYNC_COUNT=4, COM=0xBC).
// Build with SER2_TX_BYTECNT_EN defined to also cover the byte counters.
module tb_ser2_tx;

  logic       clk;
  logic       reset;
  logic [7:0] in_data1, in_data2;
  logic       in_valid1, in_valid2;
  logic       in_ready1, in_ready2;
  logic       out1, out2;
  logic       data_act1, data_act2;
  logic       almost_full_f1, almost_full_f2;
`ifdef SER2_TX_BYTECNT_EN
  logic [15:0] tx_cnt1, tx_cnt2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ser2_tx #(
    .DEPTH      (4),
    .SYNC_COUNT (4),
    .COM        (8'hBC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data1       (in_data1),
    .in_valid1      (in_valid1),
    .in_ready1      (in_ready1),
    .in_data2       (in_data2),
    .in_valid2      (in_valid2),
    .in_ready2      (in_ready2),
    .out1           (out1),
    .out2           (out2),
    .data_act1      (data_act1),
    .data_act2      (data_act2),
    .almost_full_f1 (almost_full_f1),
    .almost_full_f2 (almost_full_f2)
`ifdef SER2_TX_BYTECNT_EN
    ,
    .tx_cnt1        (tx_cnt1),
    .tx_cnt2        (tx_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {data_act, symbol} per symbol period s (edges 8s+1..8s+8) in the first run.
  function automatic logic [8:0] exp_run1(input int lane, input int s);
    if (lane == 1) begin
      case (s)
        4:       return {1'b1, 8'h5A};
        7:       return {1'b1, 8'h77};
        12:      return {1'b1, 8'hFF};
        default: return {1'b0, 8'hBC};
      endcase
    end else begin
      case (s)
        4:       return {1'b1, 8'h01};
        5:       return {1'b1, 8'h02};
        6:       return {1'b1, 8'h03};
        7:       return {1'b1, 8'h04};
        8:       return {1'b1, 8'h05};
        9:       return {1'b1, 8'h06};
        default: return {1'b0, 8'hBC};
      endcase
    end
  endfunction

  // Same, for the run after the mid-symbol reset.
  function automatic logic [8:0] exp_run2(input int lane, input int s);
    if (lane == 1) begin
      case (s)
        4:       return {1'b1, 8'h11};
        5:       return {1'b1, 8'h22};
        6:       return {1'b1, 8'h33};
        default: return {1'b0, 8'hBC};
      endcase
    end else begin
      if (s == 4) return {1'b1, 8'hBC};
      return {1'b0, 8'hBC};
    end
  endfunction

  task automatic check_lines(input int e, input logic [8:0] e1, input logic [8:0] e2);
    logic [7:0] s1, s2;
    int b;
    s1 = e1[7:0];
    s2 = e2[7:0];
    b  = 7 - ((e - 1) % 8);
    check_eq($sformatf("out1@%0d", e), {31'd0, out1}, {31'd0, s1[b]});
    check_eq($sformatf("out2@%0d", e), {31'd0, out2}, {31'd0, s2[b]});
    check_eq($sformatf("act1@%0d", e), {31'd0, data_act1}, {31'd0, e1[8]});
    check_eq($sformatf("act2@%0d", e), {31'd0, data_act2}, {31'd0, e2[8]});
  endtask

  initial begin
    int  idx2;
    logic fire2;
    reset     = 1'b0;
    in_data1  = 8'h00;
    in_valid1 = 1'b0;
    idx2      = 1;
    in_data2  = 8'h01;
    in_valid2 = 1'b1;

    #12;
    check_eq("rst_out1", {31'd0, out1}, 32'd0);
    check_eq("rst_out2", {31'd0, out2}, 32'd0);
    check_eq("rst_act1", {31'd0, data_act1}, 32'd0);
    check_eq("rst_af2", {31'd0, almost_full_f2}, 32'd0);
    check_eq("rst_rdy1", {31'd0, in_ready1}, 32'd1);
    check_eq("rst_rdy2", {31'd0, in_ready2}, 32'd1);

    @(negedge clk);
    reset = 1'b1;

    // Run 1: INIT COMs, lane 1 data during INIT, lane 2 burst, load-edge push,
    // then three bytes on lane 1 to be cut by reset.
    for (int e = 1; e <= 100; e++) begin
      in_valid1 = 1'b0;
      case (e)
        3:  begin in_valid1 = 1'b1; in_data1 = 8'h5A; end
        49: begin in_valid1 = 1'b1; in_data1 = 8'h77; end
        89: begin in_valid1 = 1'b1; in_data1 = 8'hFF; end
        90: begin in_valid1 = 1'b1; in_data1 = 8'hA5; end
        91: begin in_valid1 = 1'b1; in_data1 = 8'h3C; end
        default: ;
      endcase
      fire2 = in_valid2 && in_ready2;
      tick();
      if (fire2) begin
        idx2++;
        in_data2  = 8'(idx2);
        in_valid2 = (idx2 <= 6);
      end
      check_lines(e, exp_run1(1, (e - 1) / 8), exp_run1(2, (e - 1) / 8));
      case (e)
        2:  check_eq("af2@2", {31'd0, almost_full_f2}, 32'd0);
        3:  begin
              check_eq("af2@3", {31'd0, almost_full_f2}, 32'd1);
              check_eq("rdy2@3", {31'd0, in_ready2}, 32'd1);
            end
        4:  check_eq("rdy2@4", {31'd0, in_ready2}, 32'd0);
        32: check_eq("rdy2@32", {31'd0, in_ready2}, 32'd0);
        33: check_eq("rdy2@33", {31'd0, in_ready2}, 32'd1);
        34: check_eq("rdy2@34", {31'd0, in_ready2}, 32'd0);
        48: check_eq("af1@48", {31'd0, almost_full_f1}, 32'd0);
        default: ;
      endcase
    end
    check_eq("burst_done", idx2, 7);

`ifdef SER2_TX_BYTECNT_EN
    check_eq("cnt1_run1", {16'd0, tx_cnt1}, 32'd3);
    check_eq("cnt2_run1", {16'd0, tx_cnt2}, 32'd6);
`endif

    // Edge 100 is bit 4 of 0xFF with 0xA5, 0x3C still queued.
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_out1", {31'd0, out1}, 32'd0);
    check_eq("midrst_rdy1", {31'd0, in_ready1}, 32'd1);
    check_eq("midrst_act1", {31'd0, data_act1}, 32'd0);
`ifdef SER2_TX_BYTECNT_EN
    check_eq("midrst_cnt1", {16'd0, tx_cnt1}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Run 2: full INIT again, old queue gone; 3 bytes on lane 1, data 0xBC on lane 2.
    for (int f = 1; f <= 80; f++) begin
      in_valid1 = 1'b0;
      in_valid2 = 1'b0;
      case (f)
        2: begin in_valid1 = 1'b1; in_data1 = 8'h11; end
        3: begin in_valid1 = 1'b1; in_data1 = 8'h22; end
        4: begin in_valid1 = 1'b1; in_data1 = 8'h33; end
        5: begin in_valid2 = 1'b1; in_data2 = 8'hBC; end
        default: ;
      endcase
      tick();
      check_lines(1000 + f, exp_run2(1, (f - 1) / 8), exp_run2(2, (f - 1) / 8));
      if (f == 4)  check_eq("af1_r2@4", {31'd0, almost_full_f1}, 32'd1);
      if (f == 33) check_eq("af1_r2@33", {31'd0, almost_full_f1}, 32'd0);
    end
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;

`ifdef SER2_TX_BYTECNT_EN
    check_eq("cnt1_run2", {16'd0, tx_cnt1}, 32'd3);
    check_eq("cnt2_run2", {16'd0, tx_cnt2}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
